// File: rtl/mux16_rr_arbiter_if.sv
// Handshake and bus bundle for the 16-lane round-robin mux arbiter.
//   req[15:0]   request per lane
//   in[15:0]    mux data lanes, in[i] belongs to requester i
//   out_ready   consumer accepts current beat
//   sel[3:0]    registered mux select (granted lane)
//   gnt[15:0]   registered one-hot grant, zero when idle
//   o, o_valid  forwarded bit and its qualifier
//   busy        arbiter holds a grant
interface mux16_rr_arbiter_if;
  logic [15:0] req;
  logic [15:0] in;
  logic        out_ready;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        o;
  logic        o_valid;
  logic        busy;

  // requester/consumer side
  modport master (output req, in, out_ready,
                  input  sel, gnt, o, o_valid, busy);
  // arbiter side
  modport slave  (input  req, in, out_ready,
                  output sel, gnt, o, o_valid, busy);
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a shared 16:1 bit mux.
// A lane keeps the mux for at most MAX_BURST accepted beats, or until it
// drops its request, then priority rotates to the lane after it.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   mux16_rr_arbiter_if.slave: req/in/out_ready in,
//         sel/gnt/o/o_valid/busy out
module mux16_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst,
  mux16_rr_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state;
  logic [3:0]    sel;
  logic [3:0]    ptr;
  logic [15:0]   gnt;
  logic [CW-1:0] cnt;

  logic [3:0]    win;
  logic [3:0]    idx;
  logic          found;
  logic          busy;
  logic          o_valid;

  // First requester at or after ptr; the 4-bit add wraps 15 -> 0.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      idx = ptr + 4'(k);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign busy    = (state == GRANT);
  assign o_valid = busy & bus.req[sel];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= win;
            gnt   <= 16'(1) << win;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request wins over a final beat; o_valid is already
          // low then, so no beat is counted.
          if (!bus.req[sel]) begin
            state <= IDLE;
            gnt   <= '0;
            cnt   <= '0;
            ptr   <= sel + 4'd1;
          end else if (bus.out_ready) begin
            if (cnt == CW'(MAX_BURST - 1)) begin
              state <= IDLE;
              gnt   <= '0;
              cnt   <= '0;
              ptr   <= sel + 4'd1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel     = sel;
  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.o_valid = o_valid;
  assign bus.o       = bus.in[sel] & o_valid;
endmodule

// File: doc/mux16_rr_arbiter.md
# mux16_rr_arbiter

Round-robin arbiter and select sequencer for the team's 16:1 bit multiplexer. It shares the 16-input mux between 16 requesters, one per input lane, and drives the 4-bit select. It forwards the selected lane's bit to a single consumer over a valid/ready handshake. Each grant is limited to a burst of MAX_BURST beats so that no lane can starve the others.

## Interface
- MAX_BURST, 4, maximum beats per grant; legal range 1..16.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request per lane; req[i] = lane i wants the mux.
- in  input  16  mux data lanes; in[i] belongs to requester i.
- out_ready  input  1  consumer accepts the current beat.
- sel  output  4  registered mux select; holds the index of the granted lane.
- gnt  output  16  registered one-hot grant; all zero when idle.
- o  output  1  forwarded bit, defined as in[sel] & o_valid.
- o_valid  output  1  (state==GRANT) & req[sel]; combinational.
- busy  output  1  high while state==GRANT.

## Operation
- Registers:
  - state: IDLE or GRANT.
  - sel[3:0].
  - ptr[3:0]: lane with the highest priority.
  - cnt: beats completed in the current grant; width clog2(MAX_BURST)+1.
- IDLE behaviour:
  - gnt=0 and o_valid=0.
  - If req!=0, pick the first set bit scanning ptr, ptr+1, … , 15, 0, … , ptr-1 (mod 16).
  - Register sel=winner, gnt=1<<winner, cnt=0, state=GRANT.
  - If req==0, remain in IDLE.
- Beat definition: a beat completes on any edge where o_valid & out_ready. On a beat, cnt increments.
- Release conditions, evaluated in GRANT (either one releases):
  - (a) the edge of a beat with cnt==MAX_BURST-1;
  - (b) any edge where req[sel]==0.
- On release:
  - state=IDLE, gnt=0, cnt=0.
  - ptr=sel+1 mod 16, wrapping 15→0.
  - sel keeps its value.
- Backpressure: with o_valid=1 and out_ready=0 there is no beat. cnt, sel and gnt hold, and o tracks in[sel] live.
- Lanes other than sel have no effect while in GRANT, including changes to their req or in bits.
- Simultaneous events: if the final beat and a req[sel] drop are both possible, the drop takes priority. Since o_valid is already 0 in that cycle, no beat is counted.
- MAX_BURST=1 gives strict per-beat round robin.
- Reset values:
  - state=IDLE, ptr=0, sel=0, gnt=0, cnt=0.
  - o_valid=0, o=0, busy=0.
- Reset has priority over every transition, including mid-grant. No beat completes on the reset edge.

## Timing
- Grant latency: req sampled high at edge k while IDLE → gnt, sel and busy valid after edge k. o_valid can rise in the same cycle.
- Beat throughput: one beat per cycle while out_ready=1 and req[sel]=1.
- Release to re-grant: release at edge k → IDLE for exactly one cycle → next grant after edge k+1.
- Burst cycle budget: a full burst with no stalls occupies MAX_BURST cycles in GRANT plus 1 idle cycle.
- Combinational paths: o and o_valid depend combinationally on req[sel] and in[sel]. Only registered state feeds sel and gnt.
- No path from out_ready to sel or gnt within the same cycle.

## Test plan
- Reset:
  - Stimulus: hold rst for 2 cycles with req=16'hFFFF.
  - Required response: gnt=0, sel=0, o_valid=0 and busy=0 throughout. The first grant after release of rst is lane 0.
- Single lane, full burst:
  - Stimulus: req=16'h0020, in=16'h0020, out_ready=1, MAX_BURST=4.
  - Required response: sel=5 and gnt=16'h0020. Four beats with o=1. One idle cycle with gnt=0, then lane 5 is re-granted; ptr=6 does not block it since no other lane requests.
- Fairness, all lanes requesting:
  - Stimulus: req=16'hFFFF, out_ready=1.
  - Required response: sel sequence 0,1,2,…,15,0. Each grant lasts 4 beats, with one idle cycle between grants. in=16'hA5C3 produces o patterns of 1111, 1111, 0000, …
- Backpressure:
  - Stimulus: lane 3 granted, out_ready=0 for 3 cycles, then 1.
  - Required response: cnt held and o_valid=1 during the stall. Exactly 4 beats are counted after out_ready rises, then release.
- Request drop:
  - Stimulus: lane 9 granted with MAX_BURST=4; req[9] deasserted after 2 beats while req[2]=1.
  - Required response: o_valid drops the same cycle. Next edge goes to IDLE with ptr=10. Lane 2 is then granted (wrap-around scan 10..15,0,1,2).
- Reset mid-grant:
  - Stimulus: assert rst during beat 2 of a lane 7 grant.
  - Required response: next cycle state=IDLE, gnt=0, ptr=0. That beat is not counted.
